// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: combinational hit path, word-serial
// line refill from backing memory on a miss, fence.i-style bulk invalidate.
module icache_dm #(
  parameter int          NUM_LINES  = 16,
  parameter int          LINE_WORDS = 4,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic [31:0] instr_f,
  output logic        icache_stall,
  input  logic        invalidate,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int WB  = $clog2(LINE_WORDS);
  localparam int OFF = WB + 2;
  localparam int IB  = $clog2(NUM_LINES);
  localparam int TW  = 32 - OFF - IB;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TW-1:0]           tag_q  [NUM_LINES];
  logic [31:0]             data_q [NUM_LINES*LINE_WORDS];
  logic [WB-1:0]           beat_q;
  logic                    req_q;
  logic [31:0]             addr_q;

  logic [WB-1:0]           word;
  logic [IB-1:0]           idx;
  logic [TW-1:0]           tag;
  logic [IB-1:0]           miss_idx;
  logic [TW-1:0]           miss_tag;
  logic [31:0]             line_addr_d;
  logic                    hit;
  logic                    last_beat;
  logic                    beat_done;
  logic                    unused_pc_bits;

  assign word           = pc_f[OFF-1:2];
  assign idx            = pc_f[OFF+IB-1:OFF];
  assign tag            = pc_f[31:OFF+IB];
  assign unused_pc_bits = ^pc_f[1:0];

  // The latched miss address keeps its line bits fixed while beats step the word bits
  assign miss_idx    = addr_q[OFF+IB-1:OFF];
  assign miss_tag    = addr_q[31:OFF+IB];
  assign line_addr_d = {pc_f[31:OFF], {OFF{1'b0}}};

  assign hit          = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);
  assign icache_stall = ~hit;
  assign instr_f      = hit ? data_q[{idx, word}] : NOP_INSTR;

  assign last_beat = (beat_q == WB'(LINE_WORDS - 1));
  assign beat_done = (state_q == REFILL) && mem_ready;

  assign mem_req  = req_q;
  assign mem_addr = addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      beat_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!hit) begin
            state_q <= REFILL;
            beat_q  <= '0;
            req_q   <= 1'b1;
            addr_q  <= line_addr_d;
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (last_beat) begin
              state_q           <= IDLE;
              beat_q            <= '0;
              req_q             <= 1'b0;
              valid_q[miss_idx] <= 1'b1;
            end else begin
              beat_q <= beat_q + 1'b1;
              addr_q <= addr_q + 32'd4;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      // Invalidate overrides a final-beat valid set in the same cycle
      if (invalidate) valid_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_done) begin
      data_q[{miss_idx, beat_q}] <= mem_rdata;
      if (last_beat) tag_q[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Directed bench for icache_dm: ROM backing memory with mem[a]=a and selectable wait states.
module tb_icache_dm;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_f = '0;
  logic [31:0] instr_f;
  logic        icache_stall;
  logic        invalidate = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt = 0;
  int ready_div = 1;
  int hold_err = 0;
  int n;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] acc_q[$];
  logic [31:0] exp_q[$];

  icache_dm dut (
    .clk          (clk),
    .rst          (rst),
    .pc_f         (pc_f),
    .instr_f      (instr_f),
    .icache_stall (icache_stall),
    .invalidate   (invalidate),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr;
  assign mem_ready = ((cyc_cnt % ready_div) == (ready_div - 1));

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (mem_req && mem_ready) acc_q.push_back(mem_addr);
    if (prev_pend && mem_req && (mem_addr != prev_addr)) hold_err <= hold_err + 1;
    prev_pend <= mem_req && !mem_ready;
    prev_addr <= mem_addr;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples each cycle from the current negedge until a hit; returns stall cycles seen
  task automatic wait_hit(output int cnt);
    cnt = 0;
    #1;
    while (icache_stall && cnt < 100) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    if (cnt >= 100) check_val("hit_timeout", 32'(cnt), 32'd0);
  endtask

  task automatic check_acc(input string tag);
    check_val({tag, "_nbeats"}, 32'(acc_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
      check_val(tag, acc_q[i], exp_q[i]);
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic check_hit(input string tag, input logic [31:0] pc);
    @(negedge clk);
    pc_f = pc;
    #1;
    check_val({tag, "_stall"}, 32'(icache_stall), 32'd0);
    check_val({tag, "_instr"}, instr_f, pc);
    check_val({tag, "_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_stall", 32'(icache_stall), 32'd1);
    check_val("rst_instr", instr_f, NOP);
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_addr", mem_addr, 32'd0);

    // T1 cold miss, zero-wait memory
    @(negedge clk);
    rst = 1'b0;
    pc_f = 32'h0;
    wait_hit(n);
    check_val("t1_stalls", 32'(n), 32'd5);
    check_val("t1_instr", instr_f, 32'h0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    check_acc("t1_addr");
    check_hit("t1_hit4", 32'h4);
    check_hit("t1_hit8", 32'h8);
    check_hit("t1_hitC", 32'hC);
    check_val("t1_nofetch", 32'(acc_q.size()), 32'd0);

    // T2 wait states
    @(negedge clk);
    ready_div = 3;
    pc_f = 32'h40;
    wait_hit(n);
    check_val("t2_instr", instr_f, 32'h40);
    check_val("t2_hold", 32'(hold_err), 32'd0);
    exp_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    check_acc("t2_addr");
    @(negedge clk);
    ready_div = 1;

    // T3 conflict on index 0
    pc_f = 32'h100;
    wait_hit(n);
    check_val("t3_stalls", 32'(n), 32'd5);
    check_val("t3_instr", instr_f, 32'h100);
    @(negedge clk);
    pc_f = 32'h0;
    wait_hit(n);
    check_val("t3_back_stalls", 32'(n), 32'd5);
    check_val("t3_back_instr", instr_f, 32'h0);
    acc_q.delete();

    // T4 invalidate in IDLE, then on the final refill beat
    @(negedge clk);
    pc_f = 32'h10;
    wait_hit(n);
    check_val("t4_fill_instr", instr_f, 32'h10);
    acc_q.delete();
    @(negedge clk);
    invalidate = 1'b1;
    #1;
    check_val("t4_same_cycle_hit", 32'(icache_stall), 32'd0);
    @(negedge clk);
    invalidate = 1'b0;
    wait_hit(n);
    check_val("t4_inv_stalls", 32'(n), 32'd5);
    check_val("t4_inv_instr", instr_f, 32'h10);
    exp_q = '{32'h10, 32'h14, 32'h18, 32'h1C};
    check_acc("t4_addr");
    @(negedge clk);
    pc_f = 32'h0;
    repeat (4) @(negedge clk);
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    #1;
    check_val("t4_last_inv_miss", 32'(icache_stall), 32'd1);
    wait_hit(n);
    check_val("t4_refetch_stalls", 32'(n), 32'd5);
    check_val("t4_refetch_instr", instr_f, 32'h0);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4, 32'h8, 32'hC};
    check_acc("t4_last_addr");

    // T5 redirect mid-refill
    @(negedge clk);
    pc_f = 32'h20;
    repeat (3) @(negedge clk);
    pc_f = 32'h80;
    wait_hit(n);
    check_val("t5_stalls", 32'(n), 32'd7);
    check_val("t5_instr", instr_f, 32'h80);
    exp_q = '{32'h20, 32'h24, 32'h28, 32'h2C, 32'h80, 32'h84, 32'h88, 32'h8C};
    check_acc("t5_addr");
    check_hit("t5_hit24", 32'h24);

    // T6 reset during beat 2
    @(negedge clk);
    pc_f = 32'h30;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("t6_req_drop", 32'(mem_req), 32'd0);
    check_val("t6_rst_stall", 32'(icache_stall), 32'd1);
    check_val("t6_rst_instr", instr_f, NOP);
    @(negedge clk);
    rst = 1'b0;
    pc_f = 32'h20;
    wait_hit(n);
    check_val("t6_miss_stalls", 32'(n), 32'd5);
    check_val("t6_instr", instr_f, 32'h20);
    exp_q = '{32'h30, 32'h34, 32'h20, 32'h24, 32'h28, 32'h2C};
    check_acc("t6_addr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
